ex_wb_stage: RTL and testbench

//  Execute-to-writeback pipeline register of the 3-stage CPU. Sits directly downstream of the ALU.
//  - Latches the ALU result for register-file writeback.
//  - Owns the architectural Z/C flag register and feeds C back to the ALU carry_in.
//  - Provides WB->EX forwarding for the next instruction's source operands.
//  - Keeps a retired-instruction counter.

---
 rtl/ex_wb_stage.sv | 103 ++++++++++
 tb/tb_ex_wb_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_wb_stage.sv
// Execute-to-writeback pipeline register: latches the ALU result for register-file
// writeback, owns the Z/C flags, drives WB->EX forwarding and counts retired instructions.
module ex_wb_stage #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3,
  parameter int R0_ZERO = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               ex_valid,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic               ex_reg_we,
  input  logic               ex_flag_we,
  input  logic [RADDR_W-1:0] ex_rs1,
  input  logic [RADDR_W-1:0] ex_rs2,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_zero,
  input  logic               alu_carry_out,
  output logic               alu_carry_in,
  output logic               wb_valid,
  output logic               wb_we,
  output logic [RADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]  wb_data,
  output logic               flag_z,
  output logic               flag_c,
  output logic               fwd_rs1,
  output logic               fwd_rs2,
  output logic [CNT_W-1:0]   retired
);

  // Handshake: the EX instruction is taken on a rising edge only when ex_valid is high
  // and neither stall nor flush is high; otherwise a bubble enters WB and upstream must
  // hold the instruction for as long as stall stays high (flush simply drops it).
  logic acc;
  logic rd_is_r0;

  logic               wb_valid_q, wb_valid_d;
  logic               wb_we_q,    wb_we_d;
  logic [RADDR_W-1:0] wb_rd_q,    wb_rd_d;
  logic [DATA_W-1:0]  wb_data_q,  wb_data_d;
  logic               flag_z_q,   flag_z_d;
  logic               flag_c_q,   flag_c_d;
  logic [CNT_W-1:0]   retired_q,  retired_d;

  assign acc      = ex_valid & ~stall & ~flush;
  assign rd_is_r0 = (R0_ZERO != 0) && (ex_rd == '0);

  always_comb begin
    wb_valid_d = acc;
    wb_we_d    = acc & ex_reg_we & ~rd_is_r0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    flag_z_d   = flag_z_q;
    flag_c_d   = flag_c_q;
    retired_d  = retired_q;
    if (acc) begin
      wb_rd_d   = ex_rd;
      wb_data_d = alu_result;
      retired_d = retired_q + CNT_W'(1);
      if (ex_flag_we) begin
        flag_z_d = alu_zero;
        flag_c_d = alu_carry_out;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
      retired_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      flag_z_q   <= flag_z_d;
      flag_c_q   <= flag_c_d;
      retired_q  <= retired_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_we        = wb_we_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign flag_z       = flag_z_q;
  assign flag_c       = flag_c_q;
  assign alu_carry_in = flag_c_q;
  assign retired      = retired_q;

  // wb_we is already clear for r0, so r0 never forwards.
  assign fwd_rs1 = wb_we_q & (wb_rd_q == ex_rs1);
  assign fwd_rs2 = wb_we_q & (wb_rd_q == ex_rs2);

endmodule

// File: tb/tb_ex_wb_stage.sv
// Bench for ex_wb_stage: directed scenarios plus random traffic, checked by a
// writeback scoreboard and a cycle-level architectural model.
module tb_ex_wb_stage;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int CW = 16;
  localparam int EW = AW + DW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall, flush, ex_valid, ex_reg_we, ex_flag_we;
  logic [AW-1:0] ex_rd, ex_rs1, ex_rs2;
  logic [DW-1:0] alu_result;
  logic          alu_zero, alu_carry_out;
  logic          alu_carry_in, wb_valid, wb_we, flag_z, flag_c, fwd_rs1, fwd_rs2;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [CW-1:0] retired;

  ex_wb_stage #(.DATA_W(DW), .RADDR_W(AW), .R0_ZERO(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_flag_we(ex_flag_we),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_carry_out(alu_carry_out), .alu_carry_in(alu_carry_in),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_z(flag_z), .flag_c(flag_c), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .retired(retired)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int errors = 0;

  // scoreboard of committed writebacks: {rd, data, we}
  logic [EW-1:0] exp_q[$];

  // architectural model state, updated on each rising edge by the driver
  bit          m_valid, m_we, m_z, m_c;
  int          m_rd, m_data, m_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_valid = 0; m_we = 0; m_z = 0; m_c = 0;
    m_rd = 0; m_data = 0; m_ret = 0;
  endtask

  // ADD with carry in, returns {carry, sum}
  function automatic logic [DW:0] addc(input int a, input int b, input bit cin);
    int s;
    s = a + b + int'(cin);
    return {s >= 65536, DW'(s % 65536)};
  endfunction

  task automatic drive(input bit v, input bit st, input bit fl, input int rd,
                       input bit we, input bit fwe, input int res, input bit z, input bit co);
    bit a;
    ex_valid = v; stall = st; flush = fl; ex_rd = AW'(rd); ex_reg_we = we;
    ex_flag_we = fwe; alu_result = DW'(res); alu_zero = z; alu_carry_out = co;
    a = v && !st && !fl;
    @(posedge clk);
    m_valid = a;
    m_we = a && we && (rd != 0);
    if (a) begin
      m_rd = rd;
      m_data = res;
      m_ret = (m_ret + 1) % (1 << CW);
      if (fwe) begin
        m_z = z;
        m_c = co;
      end
      exp_q.push_back({AW'(rd), DW'(res), m_we});
    end
    #1;
  endtask

  // monitor: compare against the model away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("wb_valid", wb_valid, m_valid);
      if (wb_valid) begin
        if (exp_q.size() == 0) chk("unexpected_wb", 1, 0);
        else chk("wb_entry", {wb_rd, wb_data, wb_we}, exp_q.pop_front());
      end
      chk("wb_we", wb_we, m_we);
      chk("flag_z", flag_z, m_z);
      chk("flag_c", flag_c, m_c);
      chk("carry_in", alu_carry_in, m_c);
      chk("retired", retired, m_ret);
      chk("fwd_rs1", fwd_rs1, m_we && (m_rd == int'(ex_rs1)));
      chk("fwd_rs2", fwd_rs2, m_we && (m_rd == int'(ex_rs2)));
    end
  end

  logic [DW:0] r;
  int a_op, b_op;

  initial begin
    rst = 1'b1;
    ex_valid = 0; stall = 0; flush = 0; ex_rd = '0; ex_reg_we = 0; ex_flag_we = 0;
    ex_rs1 = '0; ex_rs2 = '0; alu_result = '0; alu_zero = 0; alu_carry_out = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", wb_valid, 0);
    chk("reset_retired", retired, 0);
    rst = 1'b0;

    // basic writeback
    drive(1, 0, 0, 3, 1, 0, 'h1234, 0, 0);
    chk("basic_we", wb_we, 1);
    chk("basic_rd", wb_rd, 3);
    chk("basic_data", wb_data, 'h1234);
    chk("basic_retired", retired, 1);

    // carry chain: FFFF + 1 then 0 + 0 + carry
    r = addc('hFFFF, 1, m_c);
    drive(1, 0, 0, 1, 1, 1, int'(r[DW-1:0]), r[DW-1:0] == 0, r[DW]);
    chk("chain1_c", flag_c, 1);
    chk("chain1_z", flag_z, 1);
    chk("chain1_cin", alu_carry_in, 1);
    r = addc(0, 0, m_c);
    drive(1, 0, 0, 2, 1, 1, int'(r[DW-1:0]), r[DW-1:0] == 0, r[DW]);
    chk("chain2_data", wb_data, 1);
    chk("chain2_c", flag_c, 0);

    // stall, flush and both: bubbles leave flags and counter alone
    drive(1, 1, 0, 4, 1, 1, 'hAAAA, 1, 1);
    chk("stall_valid", wb_valid, 0);
    chk("stall_ret", retired, 3);
    drive(1, 0, 1, 4, 1, 1, 'hAAAA, 1, 1);
    chk("flush_valid", wb_valid, 0);
    chk("flush_c", flag_c, 0);
    drive(1, 1, 1, 4, 1, 1, 'hAAAA, 1, 1);
    chk("both_valid", wb_valid, 0);
    chk("both_ret", retired, 3);

    // forwarding and r0
    drive(1, 0, 0, 5, 1, 0, 'h5555, 0, 0);
    ex_valid = 0; ex_rs1 = 3'd5; ex_rs2 = 3'd2;
    #1;
    chk("fwd5_rs1", fwd_rs1, 1);
    chk("fwd5_rs2", fwd_rs2, 0);
    drive(1, 0, 0, 0, 1, 0, 'h7777, 0, 0);
    ex_valid = 0; ex_rs1 = 3'd0;
    #1;
    chk("r0_we", wb_we, 0);
    chk("r0_fwd", fwd_rs1, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      ex_rs1 = AW'($urandom_range(0, 7));
      ex_rs2 = AW'($urandom_range(0, 7));
      a_op = $urandom_range(0, 65535);
      b_op = ($urandom_range(0, 3) == 0) ? (65536 - a_op) % 65536 : $urandom_range(0, 65535);
      r = addc(a_op, b_op, m_c);
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
            int'(r[DW-1:0]), r[DW-1:0] == 0, r[DW]);
    end

    // asynchronous reset with a live instruction in WB
    drive(1, 0, 0, 6, 1, 1, 'hBEEF, 0, 1);
    chk("pre_rst_valid", wb_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", wb_valid, 0);
    chk("rst_we", wb_we, 0);
    chk("rst_rd", wb_rd, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_flags", {flag_z, flag_c}, 0);
    chk("rst_ret", retired, 0);
    chk("rst_fwd", {fwd_rs1, fwd_rs2}, 0);
    model_reset();
    ex_valid = 0;
    @(posedge clk);
    #1 rst = 1'b0;

    // counter wrap
    while (m_ret != 65535) drive(1, 0, 0, $urandom_range(0, 7), 1, 0, $urandom_range(0, 65535), 0, 0);
    chk("pre_wrap", retired, 'hFFFF);
    drive(1, 0, 0, 1, 1, 0, 'h0101, 0, 0);
    chk("wrap", retired, 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
